// File: rtl/report_framer.sv
// Serialises a set of 7-bit values as two-digit ASCII decimal fields joined by a
// separator byte, optionally closed with CR LF, one byte per FIFO push.
module report_framer #(
    parameter int         NUM_FIELDS = 4,
    parameter logic [7:0] SEP_CHAR   = 8'h3A,
    parameter bit         EOL_EN     = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_trigger,
    input  logic [NUM_FIELDS*7-1:0] i_fields,
    input  logic [NUM_FIELDS-1:0]   i_mask,
    input  logic                    i_full,
    output logic [7:0]              o_data,
    output logic                    o_push,
    output logic                    o_busy,
    output logic                    o_overrun
);

    typedef enum logic [2:0] {
        IDLE,
        SEEK,
        TENS,
        ONES,
        SEP,
        CR,
        LF
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [NUM_FIELDS*7-1:0] fields;
    logic [NUM_FIELDS-1:0]   pending;
    logic [3:0]              tens;
    logic [3:0]              ones;
    logic                    overrun;
    logic [6:0]              sel_val;
    logic [NUM_FIELDS-1:0]   sel_bit;
    logic [6:0]              sat_val;

    function automatic logic [6:0] sat99(input logic [6:0] v);
        return (v > 7'd99) ? 7'd99 : v;
    endfunction

    function automatic logic [7:0] ascii_digit(input logic [3:0] d);
        return 8'h30 + {4'h0, d};
    endfunction

    // Lowest still-pending field wins; pending bits are cleared as fields are taken.
    always_comb begin
        sel_val = '0;
        sel_bit = '0;
        for (int n = NUM_FIELDS - 1; n >= 0; n--) begin
            if (pending[n]) begin
                sel_val    = fields[n*7 +: 7];
                sel_bit    = '0;
                sel_bit[n] = 1'b1;
            end
        end
    end

    assign sat_val = sat99(sel_val);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fields  <= '0;
            pending <= '0;
            tens    <= '0;
            ones    <= '0;
            overrun <= 1'b0;
        end else begin
            overrun <= i_trigger && (state != IDLE);
            if (state == IDLE && i_trigger) begin
                fields  <= i_fields;
                pending <= i_mask;
            end
            if (state == SEEK) begin
                tens    <= 4'(sat_val / 7'd10);
                ones    <= 4'(sat_val % 7'd10);
                pending <= pending & ~sel_bit;
            end
        end
    end

    // Emitting states push whenever the FIFO has room and only advance on a push.
    always_comb begin
        state_next = state;
        o_push     = 1'b0;
        o_data     = 8'h00;
        case (state)
            IDLE: begin
                if (i_trigger) begin
                    state_next = (i_mask == '0 && EOL_EN) ? CR : SEEK;
                end
            end
            SEEK: begin
                state_next = (pending != '0) ? TENS : IDLE;
            end
            TENS: begin
                o_push = !i_full;
                o_data = ascii_digit(tens);
                if (!i_full) state_next = ONES;
            end
            ONES: begin
                o_push = !i_full;
                o_data = ascii_digit(ones);
                if (!i_full) begin
                    if (pending != '0) state_next = SEP;
                    else               state_next = EOL_EN ? CR : IDLE;
                end
            end
            SEP: begin
                o_push = !i_full;
                o_data = SEP_CHAR;
                if (!i_full) state_next = SEEK;
            end
            CR: begin
                o_push = !i_full;
                o_data = 8'h0D;
                if (!i_full) state_next = LF;
            end
            LF: begin
                o_push = !i_full;
                o_data = 8'h0A;
                if (!i_full) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (!o_push) o_data = 8'h00;
    end

    assign o_busy    = (state != IDLE);
    assign o_overrun = overrun;

endmodule

// File: tb/tb_report_framer.sv
// Bench for report_framer: two instances (with and without CR LF) share stimulus and
// are compared against byte strings built from the field/mask rules.
module tb_report_framer;

    logic        clk    = 1'b0;
    logic        rst    = 1'b0;
    logic        trig   = 1'b0;
    logic        full   = 1'b0;
    logic [27:0] fields = '0;
    logic [3:0]  mask   = '0;
    logic [7:0]  data, data0;
    logic        push, push0, busy, busy0, ovr, ovr0;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] got[$], got0[$], exp[$], exp0[$];

    int         busy_cyc, busy0_cyc, ovr_cnt, ovr0_cnt, ovr_iter, full_push;
    bit         rel_push;
    logic [7:0] rel_data;

    always #5 clk = ~clk;

    report_framer dut (
        .clk(clk), .rst(rst), .i_trigger(trig), .i_fields(fields), .i_mask(mask),
        .i_full(full), .o_data(data), .o_push(push), .o_busy(busy), .o_overrun(ovr)
    );

    report_framer #(.EOL_EN(1'b0)) dut0 (
        .clk(clk), .rst(rst), .i_trigger(trig), .i_fields(fields), .i_mask(mask),
        .i_full(full), .o_data(data0), .o_push(push0), .o_busy(busy0), .o_overrun(ovr0)
    );

    // Reference: each enabled field, lowest first, as two decimal digits clamped at 99,
    // separated by ':'; the EOL variant adds CR LF.
    function automatic void model(input logic [27:0] f, input logic [3:0] m);
        int v;
        bit first = 1'b1;
        for (int n = 0; n < 4; n++) begin
            if (m[n]) begin
                v = int'(f[n*7 +: 7]);
                if (v > 99) v = 99;
                if (!first) begin
                    exp.push_back(8'h3A);
                    exp0.push_back(8'h3A);
                end
                exp.push_back(8'(48 + v / 10));
                exp.push_back(8'(48 + v % 10));
                exp0.push_back(8'(48 + v / 10));
                exp0.push_back(8'(48 + v % 10));
                first = 1'b0;
            end
        end
        exp.push_back(8'h0D);
        exp.push_back(8'h0A);
    endfunction

    function automatic void exp_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            exp.push_back(s[i]);
            exp0.push_back(s[i]);
        end
        exp.push_back(8'h0D);
        exp.push_back(8'h0A);
    endfunction

    function automatic bit q_eq(input logic [7:0] a[$], input logic [7:0] b[$]);
        if (a.size() != b.size()) return 1'b0;
        foreach (a[i]) if (a[i] !== b[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic string q_str(input logic [7:0] q[$]);
        string s = "";
        foreach (q[i]) s = {s, $sformatf("%02h ", q[i])};
        return s;
    endfunction

    function automatic void clear_all();
        got.delete(); got0.delete(); exp.delete(); exp0.delete();
    endfunction

    // Drives one frame from a post-edge point and collects pushed bytes at negedges.
    // Leaves the bench just after the edge where both instances are idle again.
    task automatic run_frame(input logic [27:0] f, input logic [3:0] m, input int full_pct,
                             input int stall_at, input int stall_len, input int retrig_at);
        int it         = -1;
        int stall_left = stall_len;
        bit stalled    = 1'b0;
        bit rel_seen   = 1'b0;
        busy_cyc = 0; busy0_cyc = 0; ovr_cnt = 0; ovr0_cnt = 0; ovr_iter = -1;
        full_push = 0; rel_push = 1'b0; rel_data = 8'h00;
        fields = f; mask = m; trig = 1'b1; full = 1'b0;
        forever begin
            @(negedge clk);
            if (stalled && stall_left == 0 && !full && !rel_seen) begin
                rel_seen = 1'b1;
                rel_push = push;
                rel_data = data;
            end
            if (busy)  busy_cyc++;
            if (busy0) busy0_cyc++;
            if (push)  begin got.push_back(data);   if (full) full_push++; end
            if (push0) begin got0.push_back(data0); if (full) full_push++; end
            if (ovr)   begin ovr_cnt++; ovr_iter = it; end
            if (ovr0)  ovr0_cnt++;
            @(posedge clk);
            #1;
            it++;
            if (!(busy || busy0) || it >= 200) break;
            fields = 28'($urandom());
            mask   = 4'($urandom());
            trig   = (it == retrig_at);
            if (stall_left > 0 && got.size() == stall_at) begin
                full = 1'b1;
                stall_left--;
                stalled = 1'b1;
            end else begin
                full = (int'($urandom_range(99)) < full_pct);
            end
        end
        trig = 1'b0;
        full = 1'b0;
        if (it >= 200) begin
            n_cmp++; n_fail++;
            $display("FAIL frame_timeout: still busy after %0d cycles, required idle", it);
        end
    endtask

    task automatic test_reset();
        #3;
        n_cmp++; if (push !== 1'b0) begin n_fail++; $display("FAIL reset_push: %b vs 0", push); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: %b vs 0", busy); end
        n_cmp++; if (ovr !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: %b vs 0", ovr); end
        n_cmp++; if (data !== 8'h00) begin n_fail++; $display("FAIL reset_data: %h vs 00", data); end
        n_cmp++;
        if ({push0, busy0, ovr0, data0} !== 11'h0) begin
            n_fail++; $display("FAIL reset_noeol: %b%b%b %h vs all 0", push0, busy0, ovr0, data0);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        clear_all();
        exp_str("12:34:56");
        run_frame({7'd7, 7'd56, 7'd34, 7'd12}, 4'b0111, 0, 0, 0, -1);
        n_cmp++; if (!q_eq(got, exp)) begin n_fail++; $display("FAIL basic_bytes: %s vs %s", q_str(got), q_str(exp)); end
        n_cmp++; if (!q_eq(got0, exp0)) begin n_fail++; $display("FAIL basic_bytes_noeol: %s vs %s", q_str(got0), q_str(exp0)); end
        n_cmp++; if (busy_cyc != 13) begin n_fail++; $display("FAIL basic_busy_cycles: %0d vs 13", busy_cyc); end
        n_cmp++; if (busy0_cyc != 11) begin n_fail++; $display("FAIL basic_busy_cycles_noeol: %0d vs 11", busy0_cyc); end
    endtask

    task automatic test_saturate();
        clear_all();
        exp_str("99");
        run_frame({21'($urandom()), 7'd120}, 4'b0001, 0, 0, 0, -1);
        n_cmp++; if (!q_eq(got, exp)) begin n_fail++; $display("FAIL saturate: %s vs %s", q_str(got), q_str(exp)); end
        n_cmp++; if (!q_eq(got0, exp0)) begin n_fail++; $display("FAIL saturate_noeol: %s vs %s", q_str(got0), q_str(exp0)); end
    endtask

    task automatic test_empty();
        clear_all();
        exp_str("");
        run_frame(28'($urandom()), 4'b0000, 0, 0, 0, -1);
        n_cmp++; if (!q_eq(got, exp)) begin n_fail++; $display("FAIL empty_eol: %s vs %s", q_str(got), q_str(exp)); end
        n_cmp++; if (got0.size() != 0) begin n_fail++; $display("FAIL empty_noeol_pushes: %0d vs 0", got0.size()); end
        n_cmp++; if (busy0_cyc != 1) begin n_fail++; $display("FAIL empty_noeol_busy: %0d vs 1", busy0_cyc); end
        n_cmp++; if (busy_cyc != 2) begin n_fail++; $display("FAIL empty_eol_busy: %0d vs 2", busy_cyc); end
    endtask

    task automatic test_full_stall();
        clear_all();
        exp_str("12:34:56");
        run_frame({7'd7, 7'd56, 7'd34, 7'd12}, 4'b0111, 0, 4, 5, -1);
        n_cmp++; if (full_push != 0) begin n_fail++; $display("FAIL stall_push_while_full: %0d vs 0", full_push); end
        n_cmp++;
        if (!(rel_push && rel_data == 8'h34)) begin
            n_fail++; $display("FAIL stall_release: push=%b data=%h vs push=1 data=34", rel_push, rel_data);
        end
        n_cmp++; if (!q_eq(got, exp)) begin n_fail++; $display("FAIL stall_bytes: %s vs %s", q_str(got), q_str(exp)); end
        n_cmp++; if (busy_cyc != 18) begin n_fail++; $display("FAIL stall_busy_cycles: %0d vs 18", busy_cyc); end
    endtask

    task automatic test_overrun();
        logic [27:0] f = 28'($urandom());
        clear_all();
        model(f, 4'b0111);
        run_frame(f, 4'b0111, 0, 0, 0, 2);
        n_cmp++; if (ovr_cnt != 1) begin n_fail++; $display("FAIL overrun_count: %0d vs 1", ovr_cnt); end
        n_cmp++; if (ovr_iter != 3) begin n_fail++; $display("FAIL overrun_timing: cycle %0d vs 3", ovr_iter); end
        n_cmp++; if (ovr0_cnt != 1) begin n_fail++; $display("FAIL overrun_count_noeol: %0d vs 1", ovr0_cnt); end
        n_cmp++; if (!q_eq(got, exp)) begin n_fail++; $display("FAIL overrun_bytes: %s vs %s", q_str(got), q_str(exp)); end
        n_cmp++; if (!q_eq(got0, exp0)) begin n_fail++; $display("FAIL overrun_bytes_noeol: %s vs %s", q_str(got0), q_str(exp0)); end
    endtask

    task automatic test_back_to_back();
        logic [27:0] f1 = 28'($urandom());
        logic [27:0] f2 = 28'($urandom());
        logic [3:0]  m1 = 4'($urandom_range(15, 1));
        logic [3:0]  m2 = 4'($urandom_range(15, 1));
        int          n1;
        clear_all();
        model(f1, m1);
        n1 = exp.size();
        model(f2, m2);
        run_frame(f1, m1, 0, 0, 0, -1);
        run_frame(f2, m2, 0, 0, 0, -1);
        n_cmp++; if (!q_eq(got, exp)) begin n_fail++; $display("FAIL b2b_bytes: %s vs %s", q_str(got), q_str(exp)); end
        n_cmp++; if (!q_eq(got0, exp0)) begin n_fail++; $display("FAIL b2b_bytes_noeol: %s vs %s", q_str(got0), q_str(exp0)); end
        n_cmp++;
        if (busy_cyc != exp.size() - n1 + $countones(m2)) begin
            n_fail++; $display("FAIL b2b_second_busy: %0d vs %0d", busy_cyc, exp.size() - n1 + $countones(m2));
        end
    endtask

    task automatic test_random();
        logic [27:0] f;
        logic [3:0]  m;
        for (int k = 0; k < 20; k++) begin
            f = 28'($urandom());
            m = 4'($urandom());
            clear_all();
            model(f, m);
            run_frame(f, m, 30, 0, 0, -1);
            n_cmp++; if (!q_eq(got, exp)) begin n_fail++; $display("FAIL rand%0d_bytes: %s vs %s", k, q_str(got), q_str(exp)); end
            n_cmp++; if (!q_eq(got0, exp0)) begin n_fail++; $display("FAIL rand%0d_bytes_noeol: %s vs %s", k, q_str(got0), q_str(exp0)); end
            n_cmp++; if (full_push != 0) begin n_fail++; $display("FAIL rand%0d_push_while_full: %0d vs 0", k, full_push); end
        end
    endtask

    task automatic test_reset_abort();
        int extra = 0;
        int guard = 0;
        clear_all();
        exp.push_back(8'h31); exp.push_back(8'h32); exp.push_back(8'h3A);
        fields = {7'd7, 7'd56, 7'd34, 7'd12}; mask = 4'b0111; trig = 1'b1; full = 1'b0;
        while (got.size() < 3 && guard < 50) begin
            @(negedge clk);
            if (push)  got.push_back(data);
            if (push0) got0.push_back(data0);
            @(posedge clk);
            #1 trig = 1'b0;
            guard++;
        end
        while (!push && guard < 50) begin
            @(posedge clk);
            #1 guard++;
        end
        n_cmp++; if (push !== 1'b1) begin n_fail++; $display("FAIL abort_precondition_push: %b vs 1", push); end
        rst = 1'b0;
        #1;
        n_cmp++; if (push !== 1'b0) begin n_fail++; $display("FAIL abort_push: %b vs 0", push); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: %b vs 0", busy); end
        n_cmp++; if (data !== 8'h00) begin n_fail++; $display("FAIL abort_data: %h vs 00", data); end
        n_cmp++; if ({push0, busy0} !== 2'b00) begin n_fail++; $display("FAIL abort_noeol: %b%b vs 00", push0, busy0); end
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (push || push0 || busy || busy0) extra++;
        end
        n_cmp++; if (extra != 0) begin n_fail++; $display("FAIL abort_quiet_after_release: %0d active cycles vs 0", extra); end
        n_cmp++; if (!q_eq(got, exp)) begin n_fail++; $display("FAIL abort_bytes: %s vs %s", q_str(got), q_str(exp)); end
        @(posedge clk);
        #1;
        clear_all();
        model(28'h0ABCDEF, 4'b1010);
        run_frame(28'h0ABCDEF, 4'b1010, 0, 0, 0, -1);
        n_cmp++; if (!q_eq(got, exp)) begin n_fail++; $display("FAIL abort_restart: %s vs %s", q_str(got), q_str(exp)); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturate();
        test_empty();
        test_full_stall();
        test_overrun();
        test_back_to_back();
        test_random();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
